// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================
// Package : ps2_pkg
// Brief   : Shared receive-FSM state type and PS/2 prefix codes
// Rev     : 1.0
// ============================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Odd parity: the data bits plus the parity bit must hold an odd count of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================
// Module : ps2_line_filter
// Brief  : 2-FF synchronisers and glitch filter for the PS/2 lines
// Rev    : 1.0
// ============================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_filt,
    output logic data_sync,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic [CW-1:0] r_cnt;
    logic          r_clk_filt;
    logic          r_clk_filt_d;

    // Filtered level flips only after FILTER_LEN consecutive samples at the other level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync   <= 2'b11;
            r_data_sync  <= 2'b11;
            r_cnt        <= '0;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_sync   <= {r_clk_sync[0], ps2_clk};
            r_data_sync  <= {r_data_sync[0], ps2_data};
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_sync[1];
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign clk_filt  = r_clk_filt;
    assign data_sync = r_data_sync[1];
    assign fall      = r_clk_filt_d & ~r_clk_filt;

endmodule
`default_nettype wire

// File: rtl/ps2_key_rx.sv
`default_nettype none
// ============================================================
// Module : ps2_key_rx
// Brief  : PS/2 keyboard frame receiver with E0/F0 prefix decoding
// Rev    : 1.0
// ============================================================
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic w_clk_filt;
    logic w_data;
    logic w_fall_raw;
    logic w_fall;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk       (sys_clk),
        .reset     (reset),
        .ps2_clk   (PS2Clk),
        .ps2_data  (PS2Data),
        .clk_filt  (w_clk_filt),
        .data_sync (w_data),
        .fall      (w_fall_raw)
    );

    // A fall is only honoured once the filtered level is actually low.
    assign w_fall = w_fall_raw & ~w_clk_filt;

    ps2_state_t    r_state, w_state_next;
    logic [2:0]    r_bit_cnt, w_bit_cnt_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_par, w_par_next;
    logic [TW-1:0] r_to_cnt;
    logic          r_pend_ext;
    logic          r_pend_brk;
    logic          w_timeout;
    logic          w_byte_ok;
    logic          w_err;

    assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                       (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_par_next     = r_par;
        w_byte_ok      = 1'b0;
        w_err          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    if (!w_data) begin
                        w_state_next   = ST_DATA;
                        w_bit_cnt_next = 3'd0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_fall) begin
                    w_shift_next   = {w_data, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (w_fall) begin
                    w_par_next   = w_data;
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_state_next = ST_IDLE;
                    if (parity_ok(r_shift, r_par) && w_data) begin
                        w_byte_ok = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_state_next = ST_IDLE;
            w_err        = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_par     <= w_par_next;
            if (w_fall || (r_state == ST_IDLE)) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
        end
    end

    // Prefix bytes only arm the pending flags; any other good byte publishes a key.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_pend_ext <= 1'b0;
            r_pend_brk <= 1'b0;
            key_code   <= 8'h00;
            key_break  <= 1'b0;
            key_ext    <= 1'b0;
            key_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (w_err) begin
                frame_err  <= 1'b1;
                r_pend_ext <= 1'b0;
                r_pend_brk <= 1'b0;
            end else if (w_byte_ok) begin
                if (r_shift == PS2_EXT) begin
                    r_pend_ext <= 1'b1;
                end else if (r_shift == PS2_BRK) begin
                    r_pend_brk <= 1'b1;
                end else begin
                    key_code   <= r_shift;
                    key_break  <= r_pend_brk;
                    key_ext    <= r_pend_ext;
                    key_valid  <= 1'b1;
                    r_pend_ext <= 1'b0;
                    r_pend_brk <= 1'b0;
                end
            end
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
`default_nettype none
// ============================================================
// Module : tb_ps2_key_rx
// Brief  : Scoreboard bench driving PS/2 frames into ps2_key_rx
// Rev    : 1.0
// ============================================================
module tb_ps2_key_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 3000;
    localparam int HALF        = 40;
    // Line edge -> 2 sync stages -> FILTER_LEN samples -> fall cycle -> registered strobe
    localparam int LAT         = FILTER_LEN + 3;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       PS2Clk  = 1'b1;
    logic       PS2Data = 1'b1;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       key_valid;
    logic       frame_err;
    logic       busy;

    ps2_key_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .PS2Clk    (PS2Clk),
        .PS2Data   (PS2Data),
        .key_code  (key_code),
        .key_break (key_break),
        .key_ext   (key_ext),
        .key_valid (key_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         brk;
        bit         ext;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Protocol-level model state
    bit         m_pend_ext = 1'b0;
    bit         m_pend_brk = 1'b0;
    logic [7:0] m_code     = 8'h00;
    bit         m_brk      = 1'b0;
    bit         m_ext      = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic void push_err(input int at);
        ev_t e;
        e = '{1'b1, 8'h00, 1'b0, 1'b0, at};
        exp_q.push_back(e);
        m_pend_ext = 1'b0;
        m_pend_brk = 1'b0;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit good, input int at);
        ev_t e;
        if (!good) begin
            push_err(at);
        end else if (b == 8'hE0) begin
            m_pend_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_pend_brk = 1'b1;
        end else begin
            e = '{1'b0, b, m_pend_brk, m_pend_ext, at};
            exp_q.push_back(e);
            m_code     = b;
            m_brk      = m_pend_brk;
            m_ext      = m_pend_ext;
            m_pend_ext = 1'b0;
            m_pend_brk = 1'b0;
        end
    endfunction

    // nbits < 11 abandons the frame after that many clock pulses
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] f;
        bit          good;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ~(^b) ^ bad_par;
        f[10]  = ~bad_stop;
        good   = (($countones(f[9:1]) % 2) == 1) && f[10];
        for (int i = 0; i < nbits; i++) begin
            PS2Data = f[i];
            wait_cyc(HALF);
            if (i == glitch_bit) begin
                PS2Clk = 1'b0;
                wait_cyc(3);
                PS2Clk = 1'b1;
                wait_cyc(HALF);
            end
            PS2Clk = 1'b0;
            if (i == 10) model_frame(b, good, cyc + LAT);
            wait_cyc(HALF);
            if (i == 5) check("busy_mid_frame", busy, 1);
            PS2Clk = 1'b1;
        end
        PS2Data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic idle_glitch();
        PS2Clk = 1'b0;
        wait_cyc(3);
        PS2Clk = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic start_error();
        PS2Data = 1'b1;
        wait_cyc(HALF);
        PS2Clk = 1'b0;
        push_err(cyc + LAT);
        wait_cyc(HALF);
        PS2Clk = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 4 * TIMEOUT_CYC) begin
            wait_cyc(1);
            k++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_code"},  key_code,  0);
        check({tag, "_key_break"}, key_break, 0);
        check({tag, "_key_ext"},   key_ext,   0);
        check({tag, "_key_valid"}, key_valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_busy"},      busy,      0);
    endtask

    // Monitor: every strobe must match the next expected event
    always @(negedge sys_clk) begin
        if (key_valid || frame_err) begin
            ev_t e;
            check("strobe_exclusive", int'(key_valid && frame_err), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got valid=%0d err=%0d expected none (cycle %0d)",
                         key_valid, frame_err, cyc);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_err", frame_err, e.is_err);
                if (!e.is_err) begin
                    check("key_code",  key_code,  e.code);
                    check("key_break", key_break, e.brk);
                    check("key_ext",   key_ext,   e.ext);
                end
                if (e.at >= 0) check("strobe_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        reset = 1'b1;
        wait_cyc(5);
        check_reset_outputs("por");
        reset = 1'b0;
        wait_cyc(5);

        // Plain make code
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
        // Break then extended key; prefixes give no strobe
        send_frame(8'hF0, 1'b0, 1'b0, 11, -1);
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
        send_frame(8'hE0, 1'b0, 1'b0, 11, -1);
        send_frame(8'h75, 1'b0, 1'b0, 11, -1);
        // Parity error after an F0, then a clean extended key
        send_frame(8'hF0, 1'b0, 1'b0, 11, -1);
        send_frame(8'h1C, 1'b1, 1'b0, 11, -1);
        send_frame(8'hE0, 1'b0, 1'b0, 11, -1);
        send_frame(8'h75, 1'b0, 1'b0, 11, -1);
        // Stop error, bad start bit, repeated prefix, non-prefix specials
        send_frame(8'h33, 1'b0, 1'b1, 11, -1);
        start_error();
        send_frame(8'hE0, 1'b0, 1'b0, 11, -1);
        send_frame(8'hE0, 1'b0, 1'b0, 11, -1);
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
        send_frame(8'hE1, 1'b0, 1'b0, 11, -1);
        send_frame(8'hFA, 1'b0, 1'b0, 11, -1);
        send_frame(8'hAA, 1'b0, 1'b0, 11, -1);
        drain();

        // Timeout: pending E0, then clock stops after 5 data bits
        send_frame(8'hE0, 1'b0, 1'b0, 11, -1);
        send_frame(8'h55, 1'b0, 1'b0, 6, -1);
        push_err(-1);
        wait_cyc(TIMEOUT_CYC + 50);
        drain();
        check("busy_after_timeout", busy, 0);
        send_frame(8'h29, 1'b0, 1'b0, 11, -1);

        // Short low glitches in IDLE and mid-frame
        idle_glitch();
        send_frame(8'h1C, 1'b0, 1'b0, 11, 4);
        drain();

        // Reset after the 4th data bit, with a pending break armed
        send_frame(8'hF0, 1'b0, 1'b0, 11, -1);
        send_frame(8'h6B, 1'b0, 1'b0, 5, -1);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        m_pend_ext = 1'b0;
        m_pend_brk = 1'b0;
        m_code     = 8'h00;
        m_brk      = 1'b0;
        m_ext      = 1'b0;
        wait_cyc(1);
        check_reset_outputs("mid_frame_reset");
        wait_cyc(2 * HALF);
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
        drain();

        // Random traffic with prefixes and occasional corrupted frames
        for (int n = 0; n < 30; n++) begin
            int         r;
            int         e;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            e = $urandom_range(0, 9);
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else            b = 8'($urandom);
            send_frame(b, e == 0, e == 1, 11, -1);
        end
        drain();

        // Outputs hold the last published key
        check("hold_key_code",  key_code,  m_code);
        check("hold_key_break", key_break, m_brk);
        check("hold_key_ext",   key_ext,   m_ext);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
